clk_gate_ctrl_multi: RTL and testbench
======================================

// Module: clk_gate_ctrl_multi
// PURPOSE
// Multi-channel clock-gating controller: NCH independent glitch-free gated clocks derived from clk.
// Each channel runs an idle-hysteresis FSM: clock is enabled on request, held for HOLD_CYC idle cycles, then gated.
// Per-channel ready status and saturating gate-off event counters. Global scan/test override.
// Sits between the power-management logic and the clock inputs of the gated sub-blocks.
// PARAMETERS
// NCH       4   number of gated clock channels (1..16)
// HOLD_CYC  8   idle cycles clock stays on after en_req drops (0 = gate immediately)
// WAKE_CYC  2   cycles from clock enable to ready assertion (0 = ready with enable)
// CNT_W     8   width of each gate-off event counter
// PORTS
// clk       in   1          free-running source clock
// rst_n     in   1          asynchronous active-low reset
// test_en   in   1          1 = all gated clocks forced running (scan/test)
// en_req    in   NCH        per-channel clock request, synchronous to clk
// cnt_clr   in   1          synchronous clear of all event counters
// gclk      out  NCH        gated clocks
// ready     out  NCH        channel clock running and settled
// gate_cnt  out  NCH*CNT_W  gate-off event counters, channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
// Reset (rst_n=0, async): all FSMs OFF, en_q=0, latch_q=0, gclk=0 immediately, ready=0, gate_cnt=0.
// Gating cell per channel: latch transparent while clk=0, D = en_q[i] | test_en; gclk[i] = clk & latch_q[i].
//  - latch_q reset to 0 async; gclk never produces a partial high pulse (no glitch on en_q or test_en changes).
// FSM per channel, states OFF, WAKE, ON, DRAIN; all transitions on posedge clk:
//  - OFF:   en_q=0. en_req=1 -> WAKE (WAKE_CYC>0, wake counter loaded WAKE_CYC) or ON (WAKE_CYC=0); en_q=1.
//  - WAKE:  en_q=1, ready=0. Counter decrements; reaches 1 -> ON next edge. en_req=0 during WAKE: complete WAKE, then ON->DRAIN.
//  - ON:    en_q=1, ready=1. en_req=0 -> DRAIN, hold counter loaded HOLD_CYC; if HOLD_CYC=0 -> OFF directly.
//  - DRAIN: en_q=1, ready=1. en_req=1 -> ON (counter discarded). Counter decrements each idle cycle; at 1 -> OFF.
//  - entering OFF: en_q=0, ready=0, gate_cnt[i] += 1 (saturates at 2^CNT_W-1, no wrap).
// Latency: en_req high sampled at posedge k in OFF -> first gclk rising edge at posedge k+1;
//  ready high after posedge k+WAKE_CYC (k if WAKE_CYC=0).
// Gate-off: en_req low sampled at posedge k in ON -> last gclk rising edge at posedge k+HOLD_CYC; ready low after that edge.
// ready is registered; no combinational path en_req -> ready or en_req -> gclk.
// test_en: forces latch D=1 only; FSM, ready and gate_cnt evolve normally from en_req.
// cnt_clr: all counters zero next edge; cnt_clr and an increment on same edge -> counter = 0.
// Channels fully independent; simultaneous events on several channels all honoured same cycle.
// Counters width: wake counter clog2(WAKE_CYC+1), hold counter clog2(HOLD_CYC+1), min 1 bit.
// Reset mid-operation: gclk drops within the clk-high phase that reset asserts; no pulse on rst_n release.
// TESTING
// Reset release, en_req=0, test_en=0 for 20 cycles -> gclk all 0, ready=0, gate_cnt=0.
// NCH=4, WAKE_CYC=2: en_req[0] rises at edge 10 -> gclk[0] first rise edge 11, ready[0]=1 after edge 12; other channels quiet.
// HOLD_CYC=8: en_req[1] drops at edge 30, re-asserts at edge 35 -> gclk[1] never stops, gate_cnt[1] unchanged; drop again at 50 -> last pulse edge 58, gate_cnt[1]=1.
// CNT_W=2: 5 on/off cycles on ch2 -> gate_cnt[2] saturates at 3; cnt_clr coincident with 6th gate-off -> 0.
// test_en=1 with en_req=0 -> all gclk toggle from next clk low phase, ready=0; test_en=0 -> gclk stops cleanly, no runt pulse.
// rst_n low mid clk-high with channels ON -> gclk=0 immediately, all outputs reset; checker asserts no gclk pulse < half period.

Source files
------------

// File: rtl/clk_gate_ctrl_multi.sv
// Multi-channel clock-gating controller. Each channel has an idle-hysteresis FSM that drives a
// glitch-free latch-based clock gate, plus a registered ready flag and a saturating gate-off counter.
module clk_gate_ctrl_multi #(
   parameter int NCH      = 4,
   parameter int HOLD_CYC = 8,
   parameter int WAKE_CYC = 2,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 test_en,
   input  logic [NCH-1:0]       en_req,
   input  logic                 cnt_clr,
   output logic [NCH-1:0]       gclk,
   output logic [NCH-1:0]       ready,
   output logic [NCH*CNT_W-1:0] gate_cnt
);

   typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_DRAIN} state_t;

   localparam int WK_W = (WAKE_CYC > 0) ? $clog2(WAKE_CYC + 1) : 1;
   localparam int HD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
   localparam logic [WK_W-1:0] WK_LOAD = WK_W'(WAKE_CYC);
   localparam logic [WK_W-1:0] WK_ONE  = WK_W'(1);
   localparam logic [HD_W-1:0] HD_LOAD = HD_W'(HOLD_CYC);
   localparam logic [HD_W-1:0] HD_ONE  = HD_W'(1);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      state_t           r_state;
      state_t           w_state_next;
      logic [WK_W-1:0]  r_wk;
      logic [WK_W-1:0]  w_wk_next;
      logic [HD_W-1:0]  r_hd;
      logic [HD_W-1:0]  w_hd_next;
      logic             w_gate_off;
      logic             r_en_q;
      logic             r_ready;
      logic             r_latch;
      logic [CNT_W-1:0] r_cnt;

      always_comb begin
         w_state_next = r_state;
         w_wk_next    = r_wk;
         w_hd_next    = r_hd;
         w_gate_off   = 1'b0;
         case (r_state)
            S_OFF: begin
               if (en_req[gi]) begin
                  if (WAKE_CYC == 0) begin
                     w_state_next = S_ON;
                  end else begin
                     w_state_next = S_WAKE;
                     w_wk_next    = WK_LOAD;
                  end
               end
            end
            // A request drop during wake-up is only acted on once the channel reaches ON
            S_WAKE: begin
               if (r_wk <= WK_ONE) begin
                  w_state_next = S_ON;
               end else begin
                  w_wk_next = r_wk - 1'b1;
               end
            end
            S_ON: begin
               if (!en_req[gi]) begin
                  if (HOLD_CYC == 0) begin
                     w_state_next = S_OFF;
                     w_gate_off   = 1'b1;
                  end else begin
                     w_state_next = S_DRAIN;
                     w_hd_next    = HD_LOAD;
                  end
               end
            end
            S_DRAIN: begin
               if (en_req[gi]) begin
                  w_state_next = S_ON;
               end else if (r_hd <= HD_ONE) begin
                  w_state_next = S_OFF;
                  w_gate_off   = 1'b1;
               end else begin
                  w_hd_next = r_hd - 1'b1;
               end
            end
            default: begin
               w_state_next = S_OFF;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= S_OFF;
            r_wk    <= '0;
            r_hd    <= '0;
            r_en_q  <= 1'b0;
            r_ready <= 1'b0;
         end else begin
            r_state <= w_state_next;
            r_wk    <= w_wk_next;
            r_hd    <= w_hd_next;
            r_en_q  <= (w_state_next != S_OFF);
            r_ready <= (w_state_next == S_ON) || (w_state_next == S_DRAIN);
         end
      end

      // Clear wins over a coincident gate-off increment
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (cnt_clr) begin
            r_cnt <= '0;
         end else if (w_gate_off && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      // Enable only changes while clk is low, so gclk never carries a partial pulse
      always_latch begin
         if (!rst_n) begin
            r_latch <= 1'b0;
         end else if (!clk) begin
            r_latch <= r_en_q | test_en;
         end
      end

      assign gclk[gi]                   = clk & r_latch;
      assign ready[gi]                  = r_ready;
      assign gate_cnt[gi*CNT_W +: CNT_W] = r_cnt;
   end

endmodule

// File: tb/tb_clk_gate_ctrl_multi.sv
// Bench for clk_gate_ctrl_multi: directed scenarios plus random requests, checked per cycle
// against an idle-streak timeline model, with a pulse-width monitor on every gated clock.
module tb_clk_gate_ctrl_multi;

   localparam int NCH  = 4;
   localparam int HOLD = 8;
   localparam int WAKE = 2;
   localparam int CW   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              test_en;
   logic [NCH-1:0]    en_req;
   logic              cnt_clr;
   logic [NCH-1:0]    gclk;
   logic [NCH-1:0]    ready;
   logic [NCH*CW-1:0] gate_cnt;

   clk_gate_ctrl_multi #(
      .NCH(NCH), .HOLD_CYC(HOLD), .WAKE_CYC(WAKE), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .test_en(test_en), .en_req(en_req),
      .cnt_clr(cnt_clr), .gclk(gclk), .ready(ready), .gate_cnt(gate_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
   endtask

   // Timeline model: a channel is clocked from its request edge; once wake-up has elapsed,
   // HOLD+1 consecutive idle samples switch it off.
   logic m_active [NCH];
   int   m_ton    [NCH];
   int   m_idle   [NCH];
   int   m_cnt    [NCH];
   int   ecnt = 0;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_active[i] = 1'b0;
         m_ton[i]    = 0;
         m_idle[i]   = 0;
         m_cnt[i]    = 0;
      end
   endtask

   task automatic model_edge(input logic [NCH-1:0] req, input logic clr);
      ecnt++;
      for (int i = 0; i < NCH; i++) begin
         if (!m_active[i]) begin
            if (req[i]) begin
               m_active[i] = 1'b1;
               m_ton[i]    = ecnt;
               m_idle[i]   = 0;
            end
         end else if (ecnt > m_ton[i] + WAKE) begin
            m_idle[i] = req[i] ? 0 : m_idle[i] + 1;
            if (m_idle[i] == HOLD + 1) begin
               m_active[i] = 1'b0;
               if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
            end
         end
         if (clr) m_cnt[i] = 0;
      end
   endtask

   function automatic logic [NCH-1:0] m_active_vec();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_active[i];
      return v;
   endfunction

   function automatic logic [NCH-1:0] m_ready_vec();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_active[i] && (ecnt >= m_ton[i] + WAKE);
      return v;
   endfunction

   function automatic logic [NCH*CW-1:0] m_cnt_vec();
      logic [NCH*CW-1:0] v;
      for (int i = 0; i < NCH; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
      return v;
   endfunction

   // One clock cycle: drive in the low phase, check the high phase and the next low phase
   task automatic cyc(input logic [NCH-1:0] req, input logic te, input logic clr);
      logic [NCH-1:0] exp_gclk;
      en_req   = req;
      test_en  = te;
      cnt_clr  = clr;
      exp_gclk = m_active_vec() | {NCH{te}};
      @(posedge clk);
      model_edge(req, clr);
      #1;
      chk("gclk_high", 32'(gclk), 32'(exp_gclk));
      chk("ready", 32'(ready), 32'(m_ready_vec()));
      chk("gate_cnt", 32'(gate_cnt), 32'(m_cnt_vec()));
      @(negedge clk);
      #1;
      chk("gclk_low", 32'(gclk), 32'd0);
   endtask

   // Every gated pulse must start on a clk rise and last a full half period unless cut by reset
   for (genvar gi = 0; gi < NCH; gi++) begin : g_mon
      time t_rise = 0;
      always @(posedge gclk[gi]) begin
         t_rise = $time;
         chk("gclk_rise_on_clk", 32'(clk), 32'd1);
      end
      always @(negedge gclk[gi]) begin
         if (rst_n === 1'b1) chk("gclk_pulse_width", 32'($time - t_rise), 32'd5);
      end
   end

   initial begin
      logic [NCH-1:0] rreq;
      rst_n   = 1'b0;
      test_en = 1'b0;
      en_req  = '0;
      cnt_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gclk", 32'(gclk), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_cnt", 32'(gate_cnt), 32'd0);
      rst_n = 1'b1;

      // Idle after reset
      for (int k = 0; k < 20; k++) cyc('0, 1'b0, 1'b0);

      // Channel 0 wake-up latency and gate-off
      for (int k = 0; k < 6; k++)  cyc(4'b0001, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)  cyc(4'b0000, 1'b0, 1'b0);

      // Channel 1: short drop inside the hold window, then a full drop
      for (int k = 0; k < 10; k++) cyc(4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)  cyc(4'b0000, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cyc(4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) cyc(4'b0000, 1'b0, 1'b0);
      chk("ch1_one_gate_off", 32'(gate_cnt[1*CW +: CW]), 32'd1);

      // Channel 2 counter saturation, then clear coincident with a gate-off
      for (int n = 0; n < 5; n++) begin
         cyc(4'b0100, 1'b0, 1'b0);
         for (int k = 0; k < 12; k++) cyc(4'b0000, 1'b0, 1'b0);
      end
      chk("ch2_saturated", 32'(gate_cnt[2*CW +: CW]), 32'd3);
      cyc(4'b0100, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cyc(4'b0000, 1'b0, 1'b0);
      chk("ch2_before_clr", 32'(ready[2]), 32'd1);
      cyc(4'b0000, 1'b0, 1'b1);
      chk("ch2_clr_wins", 32'(gate_cnt[2*CW +: CW]), 32'd0);
      chk("ch2_off_after_clr", 32'(ready[2]), 32'd0);

      // Test override with no requests
      for (int k = 0; k < 6; k++) cyc(4'b0000, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0, 1'b0);

      // Random requests, occasional test override and clear
      rreq = '0;
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 5) == 0) rreq[i] = ~rreq[i];
         end
         cyc(rreq, ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
      end

      // Reset in the middle of a clk-high phase with all channels running
      for (int k = 0; k < 6; k++) cyc(4'b1111, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_gclk", 32'(gclk), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_cnt", 32'(gate_cnt), 32'd0);
      model_reset();
      en_req = '0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) cyc(4'b0000, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
